// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch tick counter: FSM encoding,
// BCD digit widths and per-digit wrap limits.
package stopwatch_pkg;

  localparam int unsigned DIGIT_W           = 4;
  localparam int unsigned NUM_DIGITS        = 5;
  localparam int unsigned TENTHS_MAX        = 9;
  localparam int unsigned SEC_ONES_MAX      = 9;
  localparam int unsigned SEC_TENS_MAX      = 5;
  localparam int unsigned MIN_ONES_MAX      = 9;
  localparam int unsigned MIN_TENS_MAX_DFLT = 5;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_PAUSED = 2'd2
  } sw_state_e;

  // Digit 0 is tenths, digit 4 is minutes-tens.
  typedef logic [NUM_DIGITS-1:0][DIGIT_W-1:0] bcd_time_t;

  function automatic int unsigned digit_max(input int unsigned idx,
                                            input int unsigned min_tens_max);
    case (idx)
      0:       return TENTHS_MAX;
      1:       return SEC_ONES_MAX;
      2:       return SEC_TENS_MAX;
      3:       return MIN_ONES_MAX;
      default: return min_tens_max;
    endcase
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD counter digit with synchronous clear, wrapping at MAX and
// producing a carry when it wraps.
module bcd_digit
  import stopwatch_pkg::*;
#(
  parameter int unsigned MAX = 9
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               inc,
  output logic [DIGIT_W-1:0] value,
  output logic               carry_out
);

  assign carry_out = inc && (value == DIGIT_W'(MAX));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      value <= '0;
    end else if (clr) begin
      value <= '0;
    end else if (inc) begin
      value <= carry_out ? '0 : value + DIGIT_W'(1);
    end
  end

endmodule

// File: rtl/stopwatch_tick_counter.sv
// Stopwatch core: synchronises the toggling 10 Hz line, turns each edge into a
// tick and counts MM:SS.t in BCD under start/stop, clear and lap control.
module stopwatch_tick_counter
  import stopwatch_pkg::*;
#(
  parameter int unsigned SYNC_STAGES  = 2,
  parameter int unsigned MIN_TENS_MAX = MIN_TENS_MAX_DFLT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tick_in,
  input  logic               start_stop,
  input  logic               clear,
  input  logic               lap,
  output logic [DIGIT_W-1:0] tenths,
  output logic [DIGIT_W-1:0] sec_ones,
  output logic [DIGIT_W-1:0] sec_tens,
  output logic [DIGIT_W-1:0] min_ones,
  output logic [DIGIT_W-1:0] min_tens,
  output logic               running,
  output logic               held,
  output logic               wrap_pulse
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;
  logic                   tick_c;

  sw_state_e state_q, state_nx;
  bcd_time_t live_q, live_nx;
  bcd_time_t hold_q, hold_nx;
  bcd_time_t disp_q, disp_nx;
  logic      held_nx, wrap_nx, running_nx;

  logic                  count_en_c;
  logic [NUM_DIGITS-1:0] inc_c;
  logic [NUM_DIGITS-1:0] carry_c;

  // Synchroniser chain plus edge history; either edge of tick_in is a tick.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], tick_in};
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign tick_c     = sync_q[SYNC_STAGES-1] ^ hist_q;
  assign count_en_c = (state_q == ST_RUN) && tick_c && !clear;
  assign inc_c      = {carry_c[NUM_DIGITS-2:0], count_en_c};

  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
    bcd_digit #(
      .MAX(digit_max(gi, MIN_TENS_MAX))
    ) u_digit (
      .clk      (clk),
      .rst      (rst),
      .clr      (clear),
      .inc      (inc_c[gi]),
      .value    (live_q[gi]),
      .carry_out(carry_c[gi])
    );
  end

  // State, lap hold and display registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      hold_q     <= '0;
      disp_q     <= '0;
      held       <= 1'b0;
      running    <= 1'b0;
      wrap_pulse <= 1'b0;
    end else begin
      state_q    <= state_nx;
      hold_q     <= hold_nx;
      disp_q     <= disp_nx;
      held       <= held_nx;
      running    <= running_nx;
      wrap_pulse <= wrap_nx;
    end
  end

  // Next state, hold control and the registered display image.
  always_comb begin
    state_nx = state_q;
    hold_nx  = hold_q;
    held_nx  = held;
    wrap_nx  = 1'b0;
    live_nx  = live_q;

    if (clear) begin
      state_nx = ST_IDLE;
      hold_nx  = '0;
      held_nx  = 1'b0;
    end else begin
      if (start_stop) begin
        case (state_q)
          ST_IDLE:   state_nx = ST_RUN;
          ST_RUN:    state_nx = ST_PAUSED;
          ST_PAUSED: state_nx = ST_RUN;
          default:   state_nx = ST_IDLE;
        endcase
      end
      if (lap && (state_q != ST_IDLE)) begin
        if (held) begin
          held_nx = 1'b0;
        end else begin
          held_nx = 1'b1;
          hold_nx = live_q;
        end
      end
      wrap_nx = carry_c[NUM_DIGITS-1];
    end

    // Mirror of the digit chain's next value so the display stays registered.
    for (int i = 0; i < int'(NUM_DIGITS); i++) begin
      if (clear) begin
        live_nx[i] = '0;
      end else if (inc_c[i]) begin
        live_nx[i] = carry_c[i] ? '0 : live_q[i] + DIGIT_W'(1);
      end
    end

    disp_nx    = held_nx ? hold_nx : live_nx;
    running_nx = (state_nx == ST_RUN);
  end

  assign tenths   = disp_q[0];
  assign sec_ones = disp_q[1];
  assign sec_tens = disp_q[2];
  assign min_ones = disp_q[3];
  assign min_tens = disp_q[4];

endmodule

// File: tb/tb_stopwatch_tick_counter.sv
// Self-checking bench for stopwatch_tick_counter: a tenths-count model checked
// every cycle, plus literal checkpoints for the directed scenarios.
module tb_stopwatch_tick_counter;

  localparam int SS   = 2;
  localparam int MTM  = 5;
  localparam int FULL = (MTM + 1) * 6000;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic tick_in = 1'b0;
  logic start_stop = 1'b0;
  logic clear = 1'b0;
  logic lap = 1'b0;
  logic [3:0] tenths, sec_ones, sec_tens, min_ones, min_tens;
  logic running, held, wrap_pulse;

  int tests = 0;
  int fails = 0;
  bit check_en = 1'b0;

  stopwatch_tick_counter #(.SYNC_STAGES(SS), .MIN_TENS_MAX(MTM)) dut (
    .clk(clk), .rst(rst), .tick_in(tick_in), .start_stop(start_stop),
    .clear(clear), .lap(lap), .tenths(tenths), .sec_ones(sec_ones),
    .sec_tens(sec_tens), .min_ones(min_ones), .min_tens(min_tens),
    .running(running), .held(held), .wrap_pulse(wrap_pulse)
  );

  always #5 clk = ~clk;

  // Model: elapsed time as a plain tenths count; 0 idle, 1 run, 2 paused.
  int m_count = 0;
  int m_hold  = 0;
  int m_state = 0;
  bit m_held  = 1'b0;
  bit m_wrap  = 1'b0;
  bit smp [0:SS];

  always @(posedge clk or negedge rst) begin : model
    bit tk;
    int nc;
    if (!rst) begin
      m_count = 0; m_hold = 0; m_state = 0; m_held = 1'b0; m_wrap = 1'b0;
      for (int k = 0; k <= SS; k++) smp[k] = 1'b0;
    end else begin
      tk = smp[SS-1] ^ smp[SS];
      for (int k = SS; k > 0; k--) smp[k] = smp[k-1];
      smp[0] = tick_in;
      if (clear) begin
        m_count = 0; m_hold = 0; m_state = 0; m_held = 1'b0; m_wrap = 1'b0;
      end else begin
        m_wrap = 1'b0;
        nc = m_count;
        if (m_state == 1 && tk) begin
          nc = (m_count + 1) % FULL;
          m_wrap = (nc == 0);
        end
        if (lap && m_state != 0) begin
          if (m_held) m_held = 1'b0;
          else begin m_held = 1'b1; m_hold = m_count; end
        end
        if (start_stop) m_state = (m_state == 1) ? 2 : 1;
        m_count = nc;
      end
    end
  end

  function automatic logic [19:0] bcd_of(input int t);
    logic [19:0] r;
    r[3:0]   = 4'(t % 10);
    r[7:4]   = 4'((t / 10) % 10);
    r[11:8]  = 4'((t / 100) % 6);
    r[15:12] = 4'((t / 600) % 10);
    r[19:16] = 4'(t / 6000);
    return r;
  endfunction

  function automatic logic [19:0] dut_disp();
    return {min_tens, min_ones, sec_tens, sec_ones, tenths};
  endfunction

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    logic [22:0] got, exp;
    if (check_en) begin
      got = {dut_disp(), running, held, wrap_pulse};
      exp = {bcd_of(m_held ? m_hold : m_count), m_state == 1, m_held, m_wrap};
      tests++;
      if (got !== exp) begin
        fails++;
        if (fails <= 20)
          $display("FAIL cycle_model t=%0t got disp=%h run/held/wrap=%b required disp=%h run/held/wrap=%b",
                   $time, got[22:3], got[2:0], exp[22:3], exp[2:0]);
      end
    end
  end

  task automatic check(input string name, input logic [19:0] got, input logic [19:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h required=%h", name, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_ss();
    start_stop = 1'b1; step(1); start_stop = 1'b0;
  endtask

  task automatic pulse_clear();
    clear = 1'b1; step(1); clear = 1'b0;
  endtask

  task automatic pulse_lap();
    lap = 1'b1; step(1); lap = 1'b0;
  endtask

  task automatic toggles(input int n);
    repeat (n) begin
      tick_in = ~tick_in;
      step(int'($urandom_range(3, 1)));
    end
  endtask

  int wraps;

  initial begin
    tick_in = 1'b1;
    step(3);
    check_en = 1'b1;
    check("reset_disp", dut_disp(), 20'h00000);
    check("reset_flags", {17'd0, running, held, wrap_pulse}, 20'h0);
    rst = 1'b1;
    step(2);
    toggles(3);
    step(4);
    check("idle_no_count", dut_disp(), 20'h00000);
    check("idle_running", {19'd0, running}, 20'h0);

    // Start and measure the first-tick latency.
    pulse_ss();
    check("start_running", {19'd0, running}, 20'h1);
    tick_in = ~tick_in;
    step(1);
    check("lat_e0", dut_disp(), 20'h00000);
    step(1);
    check("lat_e1", dut_disp(), 20'h00000);
    step(1);
    check("lat_e2", dut_disp(), 20'h00001);
    toggles(24);
    step(4);
    check("count_25", dut_disp(), 20'h00025);
    check("model_25", 20'(m_count), 20'd25);

    // Lap hold while counting continues underneath.
    pulse_clear();
    pulse_ss();
    toggles(12);
    step(4);
    check("pre_lap", dut_disp(), 20'h00012);
    pulse_lap();
    toggles(10);
    step(4);
    check("lap_hold", dut_disp(), 20'h00012);
    check("lap_held", {19'd0, held}, 20'h1);
    pulse_lap();
    check("lap_release", dut_disp(), 20'h00022);
    check("lap_unheld", {19'd0, held}, 20'h0);

    // Stop coincident with a tick: tick counts, then paused.
    pulse_clear();
    pulse_ss();
    toggles(4);
    step(4);
    check("pre_stop", dut_disp(), 20'h00004);
    tick_in = ~tick_in;
    step(2);
    start_stop = 1'b1; step(1); start_stop = 1'b0;
    check("stop_tick", dut_disp(), 20'h00005);
    check("stop_paused", {19'd0, running}, 20'h0);
    toggles(3);
    step(4);
    check("paused_frozen", dut_disp(), 20'h00005);

    // Clear beats coincident start_stop, lap and tick.
    pulse_clear();
    pulse_ss();
    toggles(30);
    step(4);
    check("pre_clear", dut_disp(), 20'h00030);
    pulse_lap();
    tick_in = ~tick_in;
    step(2);
    clear = 1'b1; start_stop = 1'b1; lap = 1'b1;
    step(1);
    clear = 1'b0; start_stop = 1'b0; lap = 1'b0;
    check("clear_disp", dut_disp(), 20'h00000);
    check("clear_flags", {17'd0, running, held, wrap_pulse}, 20'h0);

    // Asynchronous reset in the middle of a run.
    pulse_ss();
    toggles(7);
    step(4);
    #3 rst = 1'b0;
    #1 check("async_rst", {dut_disp(), running, held, wrap_pulse} , 20'h0);
    @(negedge clk) rst = 1'b1;
    step(2);

    // Random control traffic.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(2, 0) == 0) tick_in = ~tick_in;
      start_stop = ($urandom_range(19, 0) == 0);
      lap        = ($urandom_range(24, 0) == 0);
      clear      = ($urandom_range(199, 0) == 0);
      step(1);
    end
    start_stop = 1'b0; lap = 1'b0; clear = 1'b0;
    step(4);

    // Run to 59:59.9 and wrap.
    pulse_clear();
    pulse_ss();
    repeat (FULL - 1) begin
      tick_in = ~tick_in;
      step(1);
    end
    step(4);
    check("full_scale", dut_disp(), 20'h59599);
    check("model_full", 20'(m_count), 20'(FULL - 1));
    tick_in = ~tick_in;
    wraps = 0;
    repeat (8) begin
      step(1);
      if (wrap_pulse === 1'b1) wraps++;
    end
    check("wrap_once", 20'(wraps), 20'd1);
    check("wrap_zero", dut_disp(), 20'h00000);
    check("wrap_running", {19'd0, running}, 20'h1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/stopwatch_tick_counter.md
Name: stopwatch_tick_counter

Overview:
- Receives the toggling 10 Hz enable line from the tick generator and treats every transition (rising or falling) as one 0.1 s event.
- Synchronises that line into the clk domain and converts each transition into a one-cycle tick.
- Counts ticks in BCD as MM:SS.t under start/stop, clear and lap control.
- Sits between the tick generator and the display/segment driver.

Parameters:
- SYNC_STAGES, 2, number of synchroniser flops on tick_in; minimum 2.
- MIN_TENS_MAX, 5, maximum value of the minutes-tens digit before the count wraps.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-low reset.
- tick_in  input  1  toggling 10 Hz line; each transition is one tenth of a second.
- start_stop  input  1  single-cycle pulse, already debounced; toggles run/pause.
- clear  input  1  single-cycle pulse; zeroes the count and returns to IDLE.
- lap  input  1  single-cycle pulse; toggles the display hold.
- tenths  output  4  BCD digit, 0-9.
- sec_ones  output  4  BCD digit, 0-9.
- sec_tens  output  4  BCD digit, 0-5.
- min_ones  output  4  BCD digit, 0-9.
- min_tens  output  4  BCD digit, 0-MIN_TENS_MAX.
- running  output  1  high while in RUN.
- held  output  1  high while the lap hold is active.
- wrap_pulse  output  1  one-cycle pulse when the count rolls from max to zero.

Behaviour:
- Reset (rst=0, asynchronous):
  - All sync flops, the edge-history flop and the live and held digit registers clear to 0.
  - State goes to IDLE.
  - running=0, held=0, wrap_pulse=0, all digits 0.
- Synchroniser and edge detect:
  - tick_in passes through SYNC_STAGES flops; a history flop stores the last synchronised value.
  - tick = sync_out XOR history.
  - A tick_in transition first captured at edge E updates the digits at edge E+SYNC_STAGES (2 cycles at default).
  - A transition that is not held stable for at least one clk cycle is not required to be counted.
- FSM states and transitions:
  - States: IDLE, RUN, PAUSED.
  - IDLE -> RUN on start_stop.
  - RUN -> PAUSED on start_stop.
  - PAUSED -> RUN on start_stop.
  - Any state -> IDLE on clear.
- Counting:
  - Ticks are counted only while the registered state is RUN.
  - A tick in the same cycle as start_stop from IDLE or PAUSED is not counted.
  - A tick in the same cycle as start_stop from RUN is counted, and the state then becomes PAUSED.
- Arithmetic: a chained BCD increment, tenths -> sec_ones -> sec_tens -> min_ones -> min_tens.
  - Each digit wraps at its maximum and carries into the next.
  - At MIN_TENS_MAX 9:59.9 (59:59.9 at default) a tick wraps all digits to 0.
  - wrap_pulse is asserted for exactly the cycle after that update.
  - State stays RUN after a wrap.
- Clear:
  - Has the highest priority and overrides a same-cycle start_stop, lap or tick.
  - Next cycle: live and held digits are 0, state is IDLE, held=0.
- Lap hold:
  - In RUN or PAUSED, a lap pulse with held=0 copies the live digits into the hold register and sets held=1.
  - A lap pulse with held=1 clears held.
  - Lap is ignored in IDLE.
  - Outputs show the hold register when held=1 and the live digits otherwise.
  - Counting continues underneath the hold.
- Post-reset spurious edge: if tick_in=1 at reset release, the first synchronised edge is discarded because the state is IDLE.

Decomposition:
- Shared package stopwatch_pkg, containing:
  - the FSM state encoding (IDLE, RUN, PAUSED);
  - the digit maximum constants (9, 5, 9, MIN_TENS_MAX);
  - the BCD digit width constant of 4.
- Sub-module bcd_digit:
  - parameter MAX;
  - inputs: clk, rst, clr, inc;
  - outputs: a 4-bit value, and carry_out, asserted when inc is high and value==MAX.
  - Instantiated 5 times in a chain.

Test Plan:
- Reset with tick_in=1, release, toggle tick_in 3 times without start_stop -> all digits stay 0 and running=0.
- start_stop, then 25 tick_in transitions -> 00:02.5 with running=1; the first digit change appears 2 cycles after the first sampled transition.
- Preload via 35999 ticks to 59:59.9, then one more transition -> digits 00:00.0, a one-cycle wrap_pulse, running=1.
- RUN at 00:01.2, lap, then 10 ticks -> outputs hold 00:01.2 with held=1; lap again -> outputs show 00:02.2.
- start_stop coincident with a tick in RUN at 00:00.4 -> 00:00.5 with state PAUSED; further ticks leave it at 00:00.5.
- clear coincident with start_stop and a tick at 00:03.0 -> next cycle 00:00.0, IDLE, held=0; rst pulsed low mid-RUN -> immediate zero, no wrap_pulse.
